alu_dec_seq: RTL

- Next-generation ALU decoder with registered outputs and a valid/ready handshake.
- Decodes RV32I plus an optional RV32M extension into an ALUop, a unit select (ALU or MDU) and an illegal flag.
- Models iterative-divider occupancy by stalling intake for a parameterised number of cycles.
- Sits between the ID and EX stages and replaces the purely combinational decoder.

---
 rtl/alu_dec_seq_if.sv | 27 ++
 rtl/alu_dec_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_dec_seq_if.sv
// ID->EX handshake bundle for the registered ALU decoder: instruction fields
// in, decoded operation out, each direction with its own valid/ready pair.
interface alu_dec_seq_if #(
    parameter int ALUOP_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic               out_valid;
    logic               out_ready;
    logic [ALUOP_W-1:0] alu_op;
    logic               unit_sel;
    logic               illegal;
    logic               div_busy;

    modport master (
        output in_valid, opcode, funct3, funct7, out_ready,
        input  in_ready, out_valid, alu_op, unit_sel, illegal, div_busy
    );

    modport slave (
        input  in_valid, opcode, funct3, funct7, out_ready,
        output in_ready, out_valid, alu_op, unit_sel, illegal, div_busy
    );
endinterface

// File: rtl/alu_dec_seq.sv
// RV32I/RV32M ALU decoder with registered outputs, valid/ready handshake and
// a stall that models iterative-divider occupancy.
module alu_dec_seq #(
    parameter int ALUOP_W    = 5,
    parameter int ENABLE_M   = 1,
    parameter int DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    alu_dec_seq_if.slave bus
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ARI_I  = 7'b0010011;
    localparam logic [6:0] OP_ARI_R  = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    localparam logic [4:0] A_ADD = 5'd0,  A_SUB = 5'd1,  A_SLL = 5'd2,  A_SLT = 5'd3;
    localparam logic [4:0] A_SLTU = 5'd4, A_XOR = 5'd5,  A_SRL = 5'd6,  A_SRA = 5'd7;
    localparam logic [4:0] A_OR = 5'd8,   A_AND = 5'd9,  A_COPY_B = 5'd10, A_XXX = 5'd31;

    typedef enum logic [1:0] {IDLE, HOLD, DIV_WAIT} state_t;

    function automatic logic [4:0] std_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return A_ADD;
            3'b001:  return A_SLL;
            3'b010:  return A_SLT;
            3'b011:  return A_SLTU;
            3'b100:  return A_XOR;
            3'b101:  return A_SRL;
            3'b110:  return A_OR;
            default: return A_AND;
        endcase
    endfunction

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;
    logic [ALUOP_W-1:0] alu_op_q;
    logic               unit_sel_q;
    logic               illegal_q;
    logic               div_busy_q;

    logic [4:0] dec_op_d;
    logic       dec_unit_d;
    logic       dec_ill_d;
    logic       dec_div_d;
    logic       accept;

    // Illegal is the default; each legal encoding clears it explicitly.
    always_comb begin
        dec_op_d   = A_XXX;
        dec_unit_d = 1'b0;
        dec_ill_d  = 1'b1;
        dec_div_d  = 1'b0;
        case (bus.opcode)
            OP_LUI: begin
                dec_op_d  = A_COPY_B;
                dec_ill_d = 1'b0;
            end
            OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE: begin
                dec_op_d  = A_ADD;
                dec_ill_d = 1'b0;
            end
            OP_ARI_R: begin
                if (bus.funct7 == F7_BASE) begin
                    dec_op_d  = std_op(bus.funct3);
                    dec_ill_d = 1'b0;
                end else if (bus.funct7 == F7_ALT) begin
                    if (bus.funct3 == 3'b000) begin
                        dec_op_d  = A_SUB;
                        dec_ill_d = 1'b0;
                    end else if (bus.funct3 == 3'b101) begin
                        dec_op_d  = A_SRA;
                        dec_ill_d = 1'b0;
                    end
                end else if (bus.funct7 == F7_MULD && ENABLE_M != 0) begin
                    dec_op_d   = {2'b10, bus.funct3};
                    dec_unit_d = 1'b1;
                    dec_ill_d  = 1'b0;
                    dec_div_d  = bus.funct3[2];
                end
            end
            OP_ARI_I: begin
                if (bus.funct3 == 3'b001) begin
                    if (bus.funct7 == F7_BASE) begin
                        dec_op_d  = A_SLL;
                        dec_ill_d = 1'b0;
                    end
                end else if (bus.funct3 == 3'b101) begin
                    if (bus.funct7 == F7_BASE) begin
                        dec_op_d  = A_SRL;
                        dec_ill_d = 1'b0;
                    end else if (bus.funct7 == F7_ALT) begin
                        dec_op_d  = A_SRA;
                        dec_ill_d = 1'b0;
                    end
                end else begin
                    dec_op_d  = std_op(bus.funct3);
                    dec_ill_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.in_ready = !flush && ((state_q == IDLE) || (state_q == HOLD && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            alu_op_q    <= '0;
            unit_sel_q  <= 1'b0;
            illegal_q   <= 1'b0;
            div_busy_q  <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            div_busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (accept) begin
                        alu_op_q   <= ALUOP_W'(dec_op_d);
                        unit_sel_q <= dec_unit_d;
                        illegal_q  <= dec_ill_d;
                        if (dec_div_d) begin
                            state_q     <= DIV_WAIT;
                            cnt_q       <= CNT_W'(DIV_CYCLES - 1);
                            out_valid_q <= 1'b0;
                            div_busy_q  <= 1'b1;
                        end else begin
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end else if (state_q == HOLD && bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                DIV_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                        div_busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.unit_sel  = unit_sel_q;
    assign bus.illegal   = illegal_q;
    assign bus.div_busy  = div_busy_q;
endmodule
